// File: rtl/snn_pkg.sv
// Shared definitions for the sigma-delta spike encoder.
//   state_t     : encoder control state (IDLE waits for a sample, RUN emits timesteps)
//   SNN_*       : default channel count and intensity width
//   ch_lsb()    : bit offset of channel ch inside the packed sample word
package snn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int SNN_NUM_CH    = 4;
  localparam int SNN_PIX_WIDTH = 4;

  function automatic int ch_lsb(input int ch, input int pix_width);
    return ch * pix_width;
  endfunction

endpackage

// File: rtl/snn_sd_channel.sv
// One sigma-delta rate-coding channel: holds the captured intensity and a
// running accumulator; the carry out of acc + pix is the spike for a step.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture pix_in and zero the accumulator
//   clear    : zero the accumulator (frame abort)
//   step     : commit acc <= (acc + pix) mod 2**PIX_WIDTH
//   pix_in   : intensity from the sample word
//   spike    : carry of acc + pix for the current step (combinational)
module snn_sd_channel
  import snn_pkg::*;
#(
  parameter int PIX_WIDTH = SNN_PIX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic                 step,
  input  logic [PIX_WIDTH-1:0] pix_in,
  output logic                 spike
);

  logic [PIX_WIDTH-1:0] pix;
  logic [PIX_WIDTH-1:0] acc;
  logic [PIX_WIDTH:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, pix};
  assign spike = sum[PIX_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix <= '0;
      acc <= '0;
    end else if (load) begin
      pix <= pix_in;
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[PIX_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/snn_spike_encoder.sv
// Sigma-delta spike encoder: accepts one multi-channel intensity sample,
// then emits WINDOW registered spike vectors, one per step_en.
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   sample_valid  : sample_data valid
//   sample_ready  : high in IDLE (decoded from state only)
//   sample_data   : NUM_CH packed intensities, channel i at [i*PIX_WIDTH +: PIX_WIDTH]
//   step_en       : advance one timestep (RUN only)
//   flush         : abort the current frame
//   spike_out     : spike vector, zero unless spike_valid
//   spike_valid   : one-cycle strobe per executed step
//   frame_done    : strobe on the last step of a frame
module snn_spike_encoder
  import snn_pkg::*;
#(
  parameter int NUM_CH    = SNN_NUM_CH,
  parameter int PIX_WIDTH = SNN_PIX_WIDTH,
  parameter int WINDOW    = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic [NUM_CH*PIX_WIDTH-1:0] sample_data,
  input  logic                        step_en,
  input  logic                        flush,
  output logic [NUM_CH-1:0]           spike_out,
  output logic                        spike_valid,
  output logic                        frame_done
);

  localparam int            CW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  state_t              state;
  logic [CW-1:0]       step_cnt;
  logic [NUM_CH-1:0]   spikes;
  logic                do_load;
  logic                do_clear;
  logic                do_step;

  assign sample_ready = (state == IDLE);

  // flush has priority over step_en so an aborted step leaves no residue
  assign do_load  = (state == IDLE) & sample_valid;
  assign do_clear = (state == RUN) & flush;
  assign do_step  = (state == RUN) & step_en & ~flush;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    snn_sd_channel #(
      .PIX_WIDTH(PIX_WIDTH)
    ) u_ch (
      .clk    (CLK),
      .rst    (RST),
      .load   (do_load),
      .clear  (do_clear),
      .step   (do_step),
      .pix_in (sample_data[ch_lsb(i, PIX_WIDTH) +: PIX_WIDTH]),
      .spike  (spikes[i])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      step_cnt    <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      spike_out   <= '0;
      spike_valid <= 1'b0;
      frame_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            state    <= RUN;
            step_cnt <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            state    <= IDLE;
            step_cnt <= '0;
          end else if (step_en) begin
            spike_out   <= spikes;
            spike_valid <= 1'b1;
            if (step_cnt == LAST) begin
              frame_done <= 1'b1;
              state      <= IDLE;
              step_cnt   <= '0;
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_spike_encoder.sv
module tb_snn_spike_encoder;

  typedef struct packed {
    logic [3:0] spk;
    logic       fd;
  } exp_t;

  logic        CLK;
  logic        RST;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] sample_data;
  logic        step_en;
  logic        flush;
  logic [3:0]  spike_out;
  logic        spike_valid;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  exp_t        q[$];
  bit          m_run = 0;
  int          m_cnt = 0;
  logic [15:0] m_pix = '0;
  int          cnt[4];

  snn_spike_encoder dut (
    .CLK          (CLK),
    .RST          (RST),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .step_en      (step_en),
    .flush        (flush),
    .spike_out    (spike_out),
    .spike_valid  (spike_valid),
    .frame_done   (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Spike at step k (1-based) iff floor(k*p/16) advances: even spread of p spikes over 16 steps.
  function automatic logic [3:0] exp_vec(logic [15:0] pix, int k);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) begin
      int p;
      p = int'(pix[c*4 +: 4]);
      v[c] = ((k * p) / 16) != (((k - 1) * p) / 16);
    end
    return v;
  endfunction

  // Called after driving inputs for a cycle: predicts what the next edge does.
  task automatic model_edge();
    if (!m_run) begin
      if (sample_valid) begin
        m_run = 1;
        m_pix = sample_data;
        m_cnt = 0;
      end
    end else if (flush) begin
      m_run = 0;
      m_cnt = 0;
    end else if (step_en) begin
      exp_t e;
      m_cnt++;
      e.spk = exp_vec(m_pix, m_cnt);
      e.fd  = (m_cnt == 16);
      q.push_back(e);
      if (m_cnt == 16) m_run = 0;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    sample_valid = 0; sample_data = '0; step_en = 0; flush = 0;
    #12;
    checks++;
    if ({spike_out, spike_valid, frame_done} !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 000000", {spike_out, spike_valid, frame_done});
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", sample_ready);
    end
    checks++;
    if ({spike_out, spike_valid, frame_done} !== 6'b0) begin
      errors++; $display("FAIL reset_idle_outputs: got %b want 000000", {spike_out, spike_valid, frame_done});
    end
  endtask

  task automatic test_rate_latency();
    int first_i = -1, fd_i = -1, strobes = 0;
    bit ready_low_ok = 1;
    clear_counts();
    for (int i = 0; i < 18; i++) begin
      sample_valid = (i == 0);
      sample_data  = {4'd15, 4'd8, 4'd1, 4'd0};
      step_en      = 1'b1;
      flush        = 1'b0;
      model_edge();
      @(posedge CLK); #1;
      checks++;
      if (sample_ready !== !m_run) begin
        errors++; $display("FAIL rate_ready i=%0d: got %b want %b", i, sample_ready, !m_run);
      end
      if (i <= 15 && sample_ready !== 1'b0) ready_low_ok = 0;
      checks++;
      if (spike_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL rate_valid i=%0d: got %b want %b", i, spike_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({spike_out, frame_done} !== {e.spk, e.fd}) begin
          errors++; $display("FAIL rate_spikes i=%0d: got %b/%b want %b/%b", i, spike_out, frame_done, e.spk, e.fd);
        end
      end else begin
        checks++;
        if ({spike_out, frame_done} !== 5'b0) begin
          errors++; $display("FAIL rate_idle_out i=%0d: got %b want 00000", i, {spike_out, frame_done});
        end
      end
      if (spike_valid === 1'b1) begin
        strobes++;
        if (first_i < 0) first_i = i;
        for (int c = 0; c < 4; c++) cnt[c] += int'(spike_out[c]);
      end
      if (frame_done === 1'b1) fd_i = i;
    end
    step_en = 0;
    checks++;
    if (strobes != 16) begin errors++; $display("FAIL rate_strobes: got %0d want 16", strobes); end
    checks++;
    if (cnt[3] != 15 || cnt[2] != 8 || cnt[1] != 1 || cnt[0] != 0) begin
      errors++; $display("FAIL rate_counts: got %0d,%0d,%0d,%0d want 15,8,1,0", cnt[3], cnt[2], cnt[1], cnt[0]);
    end
    checks++;
    if (first_i != 1) begin errors++; $display("FAIL latency_first_strobe: got %0d want 1", first_i); end
    checks++;
    if (fd_i != 16) begin errors++; $display("FAIL latency_frame_done: got %0d want 16", fd_i); end
    checks++;
    if (!ready_low_ok) begin errors++; $display("FAIL latency_ready_low: got high want low during run"); end
  endtask

  task automatic test_step_gaps();
    int strobes = 0, first_i = -1, last_i = -1;
    clear_counts();
    for (int i = 0; i < 34; i++) begin
      sample_valid = (i == 0);
      sample_data  = 16'h0008;
      step_en      = (i % 2) == 1;
      flush        = 1'b0;
      model_edge();
      @(posedge CLK); #1;
      checks++;
      if (sample_ready !== !m_run) begin
        errors++; $display("FAIL gaps_ready i=%0d: got %b want %b", i, sample_ready, !m_run);
      end
      checks++;
      if (spike_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL gaps_valid i=%0d: got %b want %b", i, spike_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({spike_out, frame_done} !== {e.spk, e.fd}) begin
          errors++; $display("FAIL gaps_spikes i=%0d: got %b/%b want %b/%b", i, spike_out, frame_done, e.spk, e.fd);
        end
      end else begin
        checks++;
        if ({spike_out, frame_done} !== 5'b0) begin
          errors++; $display("FAIL gaps_idle_out i=%0d: got %b want 00000", i, {spike_out, frame_done});
        end
      end
      if (spike_valid === 1'b1) begin
        strobes++;
        if (first_i < 0) first_i = i;
        last_i = i;
        for (int c = 0; c < 4; c++) cnt[c] += int'(spike_out[c]);
      end
    end
    step_en = 0;
    checks++;
    if (strobes != 16) begin errors++; $display("FAIL gaps_strobes: got %0d want 16", strobes); end
    checks++;
    if (cnt[0] != 8) begin errors++; $display("FAIL gaps_ch0_count: got %0d want 8", cnt[0]); end
    checks++;
    if (last_i - first_i != 30) begin errors++; $display("FAIL gaps_span: got %0d want 30", last_i - first_i); end
  endtask

  task automatic test_flush();
    int fd_seen = 0;
    clear_counts();
    for (int i = 0; i < 24; i++) begin
      sample_valid = (i == 0) || (i == 6);
      sample_data  = (i < 6) ? 16'h0307 : 16'h000F;
      step_en      = 1'b1;
      flush        = (i == 5) || (i == 6);
      if (i == 6) clear_counts();
      model_edge();
      @(posedge CLK); #1;
      checks++;
      if (sample_ready !== !m_run) begin
        errors++; $display("FAIL flush_ready i=%0d: got %b want %b", i, sample_ready, !m_run);
      end
      checks++;
      if (spike_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL flush_valid i=%0d: got %b want %b", i, spike_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({spike_out, frame_done} !== {e.spk, e.fd}) begin
          errors++; $display("FAIL flush_spikes i=%0d: got %b/%b want %b/%b", i, spike_out, frame_done, e.spk, e.fd);
        end
      end else begin
        checks++;
        if ({spike_out, frame_done} !== 5'b0) begin
          errors++; $display("FAIL flush_idle_out i=%0d: got %b want 00000", i, {spike_out, frame_done});
        end
      end
      if (i == 5) begin
        checks++;
        if ({spike_valid, frame_done, sample_ready} !== 3'b001) begin
          errors++; $display("FAIL flush_abort: got valid/done/ready %b want 001", {spike_valid, frame_done, sample_ready});
        end
      end
      if (spike_valid === 1'b1)
        for (int c = 0; c < 4; c++) cnt[c] += int'(spike_out[c]);
      if (frame_done === 1'b1) fd_seen++;
    end
    sample_valid = 0; step_en = 0; flush = 0;
    checks++;
    if (cnt[0] != 15) begin errors++; $display("FAIL flush_no_residue: got %0d want 15", cnt[0]); end
    checks++;
    if (fd_seen != 1) begin errors++; $display("FAIL flush_frame_done_count: got %0d want 1", fd_seen); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) begin
      sample_valid = (i == 0);
      sample_data  = 16'hFFFF;
      step_en      = 1'b1;
      flush        = 1'b0;
      model_edge();
      @(posedge CLK); #1;
      checks++;
      if (spike_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL arst_valid i=%0d: got %b want %b", i, spike_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({spike_out, frame_done} !== {e.spk, e.fd}) begin
          errors++; $display("FAIL arst_spikes i=%0d: got %b/%b want %b/%b", i, spike_out, frame_done, e.spk, e.fd);
        end
      end
    end
    checks++;
    if ({spike_valid, spike_out} !== 5'b11111) begin
      errors++; $display("FAIL arst_pre_state: got %b want 11111", {spike_valid, spike_out});
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({spike_out, spike_valid, frame_done} !== 6'b0) begin
      errors++; $display("FAIL arst_immediate: got %b want 000000", {spike_out, spike_valid, frame_done});
    end
    sample_valid = 0; step_en = 0; flush = 0;
    q.delete();
    m_run = 0; m_cnt = 0; m_pix = '0;
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({sample_ready, spike_valid} !== 2'b10) begin
      errors++; $display("FAIL arst_release: got ready/valid %b want 10", {sample_ready, spike_valid});
    end
    clear_counts();
    for (int i = 0; i < 18; i++) begin
      sample_valid = (i == 0);
      sample_data  = 16'hFFFF;
      step_en      = 1'b1;
      flush        = 1'b0;
      model_edge();
      @(posedge CLK); #1;
      checks++;
      if (spike_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL arst_frame_valid i=%0d: got %b want %b", i, spike_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({spike_out, frame_done} !== {e.spk, e.fd}) begin
          errors++; $display("FAIL arst_frame_spikes i=%0d: got %b/%b want %b/%b", i, spike_out, frame_done, e.spk, e.fd);
        end
      end
      if (spike_valid === 1'b1)
        for (int c = 0; c < 4; c++) cnt[c] += int'(spike_out[c]);
    end
    step_en = 0;
    checks++;
    if (cnt[0] != 15 || cnt[1] != 15 || cnt[2] != 15 || cnt[3] != 15) begin
      errors++; $display("FAIL arst_frame_counts: got %0d,%0d,%0d,%0d want 15,15,15,15", cnt[3], cnt[2], cnt[1], cnt[0]);
    end
  endtask

  task automatic test_back_to_back();
    int ca[4], cb[4];
    int frame = 0, fd_i = -1, b_first = -1;
    for (int c = 0; c < 4; c++) begin ca[c] = 0; cb[c] = 0; end
    for (int i = 0; i < 34; i++) begin
      sample_valid = 1'b1;
      sample_data  = (i == 0) ? 16'h9C3F : 16'h2E07;
      step_en      = 1'b1;
      flush        = 1'b0;
      model_edge();
      @(posedge CLK); #1;
      checks++;
      if (sample_ready !== !m_run) begin
        errors++; $display("FAIL b2b_ready i=%0d: got %b want %b", i, sample_ready, !m_run);
      end
      checks++;
      if (spike_valid !== (q.size() > 0)) begin
        errors++; $display("FAIL b2b_valid i=%0d: got %b want %b", i, spike_valid, q.size() > 0);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if ({spike_out, frame_done} !== {e.spk, e.fd}) begin
          errors++; $display("FAIL b2b_spikes i=%0d: got %b/%b want %b/%b", i, spike_out, frame_done, e.spk, e.fd);
        end
      end else begin
        checks++;
        if ({spike_out, frame_done} !== 5'b0) begin
          errors++; $display("FAIL b2b_idle_out i=%0d: got %b want 00000", i, {spike_out, frame_done});
        end
      end
      if (spike_valid === 1'b1) begin
        if (frame == 1 && b_first < 0) b_first = i;
        for (int c = 0; c < 4; c++) begin
          if (frame == 0) ca[c] += int'(spike_out[c]);
          else            cb[c] += int'(spike_out[c]);
        end
      end
      if (frame_done === 1'b1) begin
        if (frame == 0) fd_i = i;
        frame++;
      end
    end
    sample_valid = 0; step_en = 0;
    checks++;
    if (ca[3] != 9 || ca[2] != 12 || ca[1] != 3 || ca[0] != 15) begin
      errors++; $display("FAIL b2b_counts_a: got %0d,%0d,%0d,%0d want 9,12,3,15", ca[3], ca[2], ca[1], ca[0]);
    end
    checks++;
    if (cb[3] != 2 || cb[2] != 14 || cb[1] != 0 || cb[0] != 7) begin
      errors++; $display("FAIL b2b_counts_b: got %0d,%0d,%0d,%0d want 2,14,0,7", cb[3], cb[2], cb[1], cb[0]);
    end
    checks++;
    if (b_first - fd_i != 2) begin
      errors++; $display("FAIL b2b_gap: got %0d want 2", b_first - fd_i);
    end
    checks++;
    if (frame != 2) begin errors++; $display("FAIL b2b_frames: got %0d want 2", frame); end
  endtask

  initial begin
    test_reset();
    test_rate_latency();
    test_step_gaps();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
